// File: rtl/access_pkg.sv
// Shared definitions for the access-control block: status codes, FSM states
// and the built-in user table.
package access_pkg;

  localparam int TABLE_SIZE = 4;
  localparam int CRED_W     = 16;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ENTER  = 2'd1;
  localparam logic [1:0] ST_DENIED = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_GET_ID = 3'd1,
    S_GET_PW = 3'd2,
    S_CHECK  = 3'd3,
    S_GRANT  = 3'd4,
    S_DONE   = 3'd5,
    S_DENY   = 3'd6,
    S_LOCKED = 3'd7
  } state_e;

  // Entry [i] of USER_IDS pairs with entry [i] of USER_PWS.
  localparam logic [TABLE_SIZE-1:0][CRED_W-1:0] USER_IDS =
    {16'h0004, 16'h0003, 16'h0002, 16'h0001};
  localparam logic [TABLE_SIZE-1:0][CRED_W-1:0] USER_PWS =
    {16'h4444, 16'h3333, 16'h2222, 16'h1111};

endpackage

// File: rtl/access_rom.sv
// Combinational credential lookup against the user table; reports whether any
// entry matches and the lowest matching index.
module access_rom
  import access_pkg::*;
#(
  parameter int NUM_USERS = TABLE_SIZE,
  parameter int IDX_W     = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1
) (
  input  logic [CRED_W-1:0] id_i,
  input  logic [CRED_W-1:0] pw_i,
  output logic              match_o,
  output logic [IDX_W-1:0]  index_o
);

  logic [NUM_USERS-1:0] hit;

  generate
    for (genvar gi = 0; gi < NUM_USERS; gi++) begin : g_entry
      assign hit[gi] = (id_i == USER_IDS[gi]) && (pw_i == USER_PWS[gi]);
    end
  endgenerate

  always_comb begin
    match_o = |hit;
    index_o = '0;
    for (int i = NUM_USERS - 1; i >= 0; i--) begin
      if (hit[i]) index_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/access_control.sv
// Login responder: collects ID and password digit by digit, checks them against
// the user table, reports status and enforces a lockout after repeated failures.
module access_control
  import access_pkg::*;
#(
  parameter int NUM_USERS      = TABLE_SIZE,
  parameter int DIGITS         = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  switches,
  input  logic        enter,
  output logic        access_fb,
  output logic [15:0] userid,
  output logic [1:0]  status,
  output logic [2:0]  digit_count,
  output logic        field
);

  localparam int ID_W  = 4 * DIGITS;
  localparam int ATT_W = $clog2(MAX_ATTEMPTS + 1);
  localparam int TMR_W = $clog2(LOCKOUT_CYCLES);
  localparam int IDX_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   pw_q, pw_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ATT_W-1:0]  att_q, att_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [15:0]       userid_q, userid_d;
  logic              enter_q;
  logic              denied_q, denied_d;

  logic              press;
  logic              last_digit;
  logic [ATT_W-1:0]  att_inc;
  logic              rom_match;
  logic [IDX_W-1:0]  rom_idx;

  assign press      = enter & ~enter_q;
  assign last_digit = (cnt_q == 3'(DIGITS - 1));
  assign att_inc    = att_q + ATT_W'(1);

  access_rom #(
    .NUM_USERS (NUM_USERS),
    .IDX_W     (IDX_W)
  ) u_rom (
    .id_i    (id_q),
    .pw_i    (pw_q),
    .match_o (rom_match),
    .index_o (rom_idx)
  );

  always_comb begin
    state_d  = state_q;
    id_d     = id_q;
    pw_d     = pw_q;
    cnt_d    = cnt_q;
    att_d    = att_q;
    tmr_d    = tmr_q;
    userid_d = userid_q;
    denied_d = denied_q;

    // Losing the switches abandons any entry in progress; the attempt count survives.
    if (!enable && (state_q == S_GET_ID || state_q == S_GET_PW ||
                    state_q == S_CHECK  || state_q == S_DENY)) begin
      state_d  = S_IDLE;
      id_d     = '0;
      pw_d     = '0;
      cnt_d    = '0;
      denied_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          denied_d = 1'b0;
          if (enable) state_d = S_GET_ID;
        end
        S_GET_ID: begin
          if (press) begin
            id_d     = {id_q[ID_W-5:0], switches};
            denied_d = 1'b0;
            if (last_digit) begin
              cnt_d   = '0;
              state_d = S_GET_PW;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        S_GET_PW: begin
          if (press) begin
            pw_d = {pw_q[ID_W-5:0], switches};
            if (last_digit) begin
              cnt_d   = 3'(DIGITS);
              state_d = S_CHECK;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        S_CHECK: begin
          state_d = rom_match ? S_GRANT : S_DENY;
        end
        S_GRANT: begin
          // The matched table entry carries the same value as id_q.
          userid_d = USER_IDS[rom_idx];
          att_d    = '0;
          pw_d     = '0;
          cnt_d    = '0;
          state_d  = S_DONE;
        end
        S_DONE: begin
          if (!enable) state_d = S_IDLE;
        end
        S_DENY: begin
          att_d = att_inc;
          id_d  = '0;
          pw_d  = '0;
          cnt_d = '0;
          if (att_inc == ATT_W'(MAX_ATTEMPTS)) begin
            tmr_d   = TMR_W'(LOCKOUT_CYCLES - 1);
            state_d = S_LOCKED;
          end else begin
            denied_d = 1'b1;
            state_d  = S_GET_ID;
          end
        end
        S_LOCKED: begin
          if (tmr_q == '0) begin
            att_d   = '0;
            state_d = enable ? S_GET_ID : S_IDLE;
          end else begin
            tmr_d = tmr_q - TMR_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      id_q     <= '0;
      pw_q     <= '0;
      cnt_q    <= '0;
      att_q    <= '0;
      tmr_q    <= '0;
      userid_q <= '0;
      enter_q  <= 1'b0;
      denied_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      pw_q     <= pw_d;
      cnt_q    <= cnt_d;
      att_q    <= att_d;
      tmr_q    <= tmr_d;
      userid_q <= userid_d;
      enter_q  <= enter;
      denied_q <= denied_d;
    end
  end

  always_comb begin
    case (state_q)
      S_GET_ID: status = denied_q ? ST_DENIED : ST_ENTER;
      S_GET_PW: status = ST_ENTER;
      S_CHECK:  status = ST_ENTER;
      S_DENY:   status = ST_DENIED;
      S_LOCKED: status = ST_LOCKED;
      default:  status = ST_IDLE;
    endcase
  end

  assign access_fb   = (state_q == S_GRANT);
  assign field       = (state_q == S_GET_PW);
  assign digit_count = cnt_q;
  assign userid      = userid_q;

endmodule

// File: doc/access_control.md
Name: access_control

Overview:
- Responder for the process controller's access-control phase: collects a 4-digit user ID and a 4-digit password from the switches, one digit per enter-button press.
- Checks the pair against the user table and returns a one-cycle access_fb pulse plus the 16-bit userid on success.
- Drives a status code for LCD/LED messages, counts failed attempts and enforces a lockout.
- Sits between the switch/button muxes and the process controller.

Parameters:
- NUM_USERS, 4, entries in the user table.
- DIGITS, 4, nibbles per ID and per password (16 bits each).
- MAX_ATTEMPTS, 3, consecutive failures that trigger lockout.
- LOCKOUT_CYCLES, 1000, lockout duration in clk cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- enable  in  1  high while the process controller grants switches to this block.
- switches  in  4  digit value (hex nibble).
- enter  in  1  debounced enter button, level.
- access_fb  out  1  one-cycle pulse on successful login.
- userid  out  16  ID of the last successful login.
- status  out  2  0 idle, 1 entering, 2 denied, 3 locked.
- digit_count  out  3  digits captured in the current field (LCD cursor).
- field  out  1  0 = ID field, 1 = password field.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; access_fb=0, userid=0, status=0, digit_count=0, field=0; shift registers, attempt counter and lockout timer all 0; enter_q=0.
- Edge detect: enter_q registers enter each cycle; press = enter & ~enter_q. A held button yields exactly one press.
- Digit capture: on each press in GET_ID/GET_PW, reg <= {reg[11:0], switches} and digit_count++.
- IDLE: status=0. enable=1 -> GET_ID next cycle. A press in that same cycle is ignored.
- GET_ID:
  - field=0; status=1, except it stays 2 after a deny until the first new press.
  - After the DIGITS-th press: digit_count=0, go to GET_PW.
- GET_PW: field=1, status=1. After the DIGITS-th press: go to CHECK.
- CHECK (1 cycle):
  - Combinational match over all entries: id_reg==ID[i] and pw_reg==PW[i].
  - If any entry matches -> GRANT, else -> DENY.
- GRANT (1 cycle):
  - access_fb=1 for exactly this cycle.
  - userid<=id_reg; attempts<=0; pw_reg cleared.
  - Go to DONE.
- DONE:
  - status=0, access_fb=0.
  - Stay while enable=1; enable=0 -> IDLE.
  - userid holds until the next grant or reset.
- DENY (1 cycle):
  - status=2; attempts++; both shift registers cleared; digit_count=0.
  - If the new attempts value == MAX_ATTEMPTS: load timer=LOCKOUT_CYCLES-1, go to LOCKED.
  - Otherwise go to GET_ID.
- LOCKED:
  - status=3; presses ignored; the timer decrements every cycle regardless of enable.
  - At timer==0: attempts<=0; go to GET_ID if enable=1, else IDLE.
  - Lockout lasts exactly LOCKOUT_CYCLES cycles.
- enable=0 in GET_ID/GET_PW/CHECK/DENY: abort to IDLE next cycle.
  - Shift registers and digit_count cleared; attempts retained.
  - Abort wins over a simultaneous press or completion.
- No userid change on failure. access_fb never asserts outside GRANT.
- Widths:
  - attempts is $clog2(MAX_ATTEMPTS+1) bits and never exceeds MAX_ATTEMPTS.
  - timer is $clog2(LOCKOUT_CYCLES) bits.
  - digit_count saturates at DIGITS; it cannot overflow because the FSM leaves the field on completion.
- Mid-operation reset: full return to reset values next cycle, including lockout.

Decomposition:
- Shared package access_pkg holds:
  - status encodings (ST_IDLE=0, ST_ENTER=1, ST_DENIED=2, ST_LOCKED=3);
  - FSM state enum;
  - the user table constants: IDs 16'h0001..16'h0004, passwords 16'h1111, 16'h2222, 16'h3333, 16'h4444.
- Sub-module access_rom: combinational; takes id, pw; returns match and index. Keeps the table swappable.

Test Plan:
- Valid login: after enable=1, enter digits 0,0,0,1 then 1,1,1,1 -> access_fb pulses exactly 1 cycle, 2 cycles after the 8th press; userid=16'h0001; status=0.
- Wrong password: ID 0002, PW 2223 -> status=2, no access_fb, userid unchanged (0), field=0, digit_count=0.
- Lockout: 3 consecutive bad logins -> status=3 for exactly LOCKOUT_CYCLES cycles with presses ignored; then status!=3, attempts=0, and a valid 0003/3333 login succeeds.
- Held button: enter held high for 20 cycles -> digit_count increments by 1 only.
- Abort: drop enable after 2 password digits -> IDLE next cycle, digit_count=0. Re-enable and a full valid 0004/4444 login gives userid=16'h0004.
- Reset: rst=0 during LOCKED -> all outputs 0 next cycle; after rst=1 and enable=1, a valid login succeeds immediately.
